// File: rtl/dispatch_pkg.sv
// Shared types and constants for the in-order dispatch scheduler.
package dispatch_pkg;

  localparam int unsigned INSTR_W        = 75;
  localparam int unsigned MAJOR_LSB      = 71;
  localparam int unsigned SRC1_LSB       = 66;
  localparam int unsigned SRC2_LSB       = 61;
  localparam int unsigned OSCALE_LSB     = 59;
  localparam int unsigned DEST_LSB       = 54;
  localparam int unsigned MINOR_LSB      = 50;
  localparam int unsigned HAS_ADDR_BIT   = 49;
  localparam int unsigned ADDR_LSB       = 1;
  localparam int unsigned OFFSET_SUB_BIT = 0;

  localparam logic [3:0] OP_INT_MAX = 4'h3;
  localparam logic [3:0] OP_FADD    = 4'h4;
  localparam logic [3:0] OP_FMUL    = 4'h5;
  localparam logic [3:0] OP_LOAD    = 4'h6;
  localparam logic [3:0] OP_STORE   = 4'h7;

  localparam int unsigned NUM_CLASSES = 4;

  typedef enum logic [1:0] {
    ClsInt  = 2'd0,
    ClsFadd = 2'd1,
    ClsFmul = 2'd2,
    ClsLsb  = 2'd3
  } rs_class_e;

  typedef enum logic [1:0] {
    StRun,
    StBlocked,
    StFlush
  } state_e;

  // Opcodes 0x8-0xF have no reservation station.
  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_STORE;
  endfunction

  function automatic rs_class_e op_class(input logic [3:0] op);
    if (op <= OP_INT_MAX) return ClsInt;
    if (op == OP_FADD) return ClsFadd;
    if (op == OP_FMUL) return ClsFmul;
    return ClsLsb;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Reservation-station slot credit counter; avail is high while any slot is free.
module credit_counter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic take,
  input  logic give,
  input  logic flush,
  output logic avail
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = Full;
    end else if (take && !give) begin
      cnt_d = cnt_q - CntW'(1);
    end else if (give && !take && cnt_q != Full) begin
      // A stray return with every slot already free is dropped.
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= Full;
    else     cnt_q <= cnt_d;
  end

  assign avail = cnt_q != '0;

endmodule

// File: rtl/dispatch_scheduler.sv
// In-order issue: classifies the queue head, allocates a ROB tag and dispatches
// only when the target station and ROB both have space.
module dispatch_scheduler
  import dispatch_pkg::*;
#(
  parameter int unsigned INT_DEPTH  = 4,
  parameter int unsigned FADD_DEPTH = 3,
  parameter int unsigned FMUL_DEPTH = 2,
  parameter int unsigned LSB_DEPTH  = 4,
  parameter int unsigned ROB_DEPTH  = 8,
  parameter int unsigned TAG_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iq_valid_in,
  input  logic [INSTR_W-1:0] iq_instr_in,
  output logic               iq_ready_out,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic [3:0]         credit_ret_in,
  input  logic               rob_retire_in,
  output logic [3:0]         disp_valid_out,
  output logic [INSTR_W-1:0] disp_instr_out,
  output logic [TAG_W-1:0]   disp_tag_out,
  output logic               illegal_out,
  output logic               stall_out,
  output logic [15:0]        stall_cnt_out
);

  localparam logic [TAG_W:0] RobFull = (TAG_W + 1)'(ROB_DEPTH);

  state_e                 state_q, state_d;
  rs_class_e              cls;
  logic                   legal, can_go, alloc, rob_full, retire_ok;
  logic [NUM_CLASSES-1:0] avail, take;
  logic [TAG_W-1:0]       tail_q, tail_d;
  logic [TAG_W:0]         rob_cnt_q, rob_cnt_d;
  logic [15:0]            stall_cnt_q;

  assign cls       = op_class(iq_instr_in[MAJOR_LSB +: 4]);
  assign legal     = is_legal(iq_instr_in[MAJOR_LSB +: 4]);
  assign rob_full  = rob_cnt_q == RobFull;
  assign retire_ok = rob_retire_in && rob_cnt_q != '0;

  // Illegal opcodes drain without needing a station slot or ROB entry.
  assign can_go = iq_valid_in && !stall_in && !flush_in && state_q != StFlush &&
                  (!legal || (avail[cls] && !rob_full));
  assign alloc        = can_go && legal;
  assign take         = alloc ? (NUM_CLASSES'(1) << cls) : '0;
  assign iq_ready_out = can_go;

  credit_counter #(.DEPTH(INT_DEPTH)) u_cred_int (
    .clk(clk), .rst(rst), .take(take[ClsInt]), .give(credit_ret_in[ClsInt]),
    .flush(flush_in), .avail(avail[ClsInt])
  );
  credit_counter #(.DEPTH(FADD_DEPTH)) u_cred_fadd (
    .clk(clk), .rst(rst), .take(take[ClsFadd]), .give(credit_ret_in[ClsFadd]),
    .flush(flush_in), .avail(avail[ClsFadd])
  );
  credit_counter #(.DEPTH(FMUL_DEPTH)) u_cred_fmul (
    .clk(clk), .rst(rst), .take(take[ClsFmul]), .give(credit_ret_in[ClsFmul]),
    .flush(flush_in), .avail(avail[ClsFmul])
  );
  credit_counter #(.DEPTH(LSB_DEPTH)) u_cred_lsb (
    .clk(clk), .rst(rst), .take(take[ClsLsb]), .give(credit_ret_in[ClsLsb]),
    .flush(flush_in), .avail(avail[ClsLsb])
  );

  always_comb begin
    tail_d    = tail_q;
    rob_cnt_d = rob_cnt_q;
    if (flush_in) begin
      tail_d    = '0;
      rob_cnt_d = '0;
    end else begin
      if (alloc) tail_d = tail_q + TAG_W'(1);
      if (alloc && !retire_ok)      rob_cnt_d = rob_cnt_q + (TAG_W + 1)'(1);
      else if (retire_ok && !alloc) rob_cnt_d = rob_cnt_q - (TAG_W + 1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_in) begin
      state_d = StFlush;
    end else begin
      case (state_q)
        StRun:     if (iq_valid_in && !stall_in && !can_go) state_d = StBlocked;
        StBlocked: if (!stall_in && (can_go || !iq_valid_in)) state_d = StRun;
        StFlush:   state_d = StRun;
        default:   state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StRun;
      tail_q         <= '0;
      rob_cnt_q      <= '0;
      stall_cnt_q    <= '0;
      disp_valid_out <= '0;
      disp_instr_out <= '0;
      disp_tag_out   <= '0;
      illegal_out    <= 1'b0;
    end else begin
      state_q        <= state_d;
      tail_q         <= tail_d;
      rob_cnt_q      <= rob_cnt_d;
      disp_valid_out <= take;
      illegal_out    <= can_go && !legal;
      if (alloc) begin
        disp_instr_out <= iq_instr_in;
        disp_tag_out   <= tail_q;
      end
      if (state_q == StBlocked && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_out     = state_q == StBlocked;
  assign stall_cnt_out = stall_cnt_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler with a dispatch scoreboard.
module tb_dispatch_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        iq_valid_in;
  logic [74:0] iq_instr_in;
  logic        iq_ready_out;
  logic        stall_in;
  logic        flush_in;
  logic [3:0]  credit_ret_in;
  logic        rob_retire_in;
  logic [3:0]  disp_valid_out;
  logic [74:0] disp_instr_out;
  logic [2:0]  disp_tag_out;
  logic        illegal_out;
  logic        stall_out;
  logic [15:0] stall_cnt_out;

  typedef struct {
    logic [3:0]  strobe;
    logic [74:0] instr;
    logic [2:0]  tag;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] exp_tag;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  dispatch_scheduler #(
    .INT_DEPTH(8), .FADD_DEPTH(3), .FMUL_DEPTH(2), .LSB_DEPTH(4), .ROB_DEPTH(8), .TAG_W(3)
  ) dut (
    .clk(clk), .rst(rst), .iq_valid_in(iq_valid_in), .iq_instr_in(iq_instr_in),
    .iq_ready_out(iq_ready_out), .stall_in(stall_in), .flush_in(flush_in),
    .credit_ret_in(credit_ret_in), .rob_retire_in(rob_retire_in),
    .disp_valid_out(disp_valid_out), .disp_instr_out(disp_instr_out),
    .disp_tag_out(disp_tag_out), .illegal_out(illegal_out), .stall_out(stall_out),
    .stall_cnt_out(stall_cnt_out)
  );

  task automatic chk(input string name, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_strobe(input logic [3:0] op);
    if (op < 4'h4) return 4'b0001;
    if (op == 4'h4) return 4'b0010;
    if (op == 4'h5) return 4'b0100;
    return 4'b1000;
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    iq_valid_in   = 1'b0;
    iq_instr_in   = '0;
    stall_in      = 1'b0;
    flush_in      = 1'b0;
    credit_ret_in = '0;
    rob_retire_in = 1'b0;
    #2;
    chk("rst_ready",    80'(iq_ready_out),   80'(0));
    chk("rst_valid",    80'(disp_valid_out), 80'(0));
    chk("rst_instr",    80'(disp_instr_out), 80'(0));
    chk("rst_tag",      80'(disp_tag_out),   80'(0));
    chk("rst_illegal",  80'(illegal_out),    80'(0));
    chk("rst_stall",    80'(stall_out),      80'(0));
    chk("rst_stallcnt", 80'(stall_cnt_out),  80'(0));
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_tag = '0;
    sb.delete();
  endtask

  // One cycle: drive at edge+1, check ready before the edge, check outputs after it.
  task automatic step(input logic v, input logic [3:0] op, input logic exp_rdy,
                      input logic [3:0] cr = 4'b0, input logic ret = 1'b0,
                      input logic flsh = 1'b0, input logic stl = 1'b0);
    logic [70:0] r;
    logic [74:0] ins;
    logic        hs;
    exp_t        e;
    r[31:0]  = $urandom();
    r[63:32] = $urandom();
    r[70:64] = 7'($urandom());
    ins = {op, r};
    iq_valid_in   = v;
    iq_instr_in   = ins;
    credit_ret_in = cr;
    rob_retire_in = ret;
    flush_in      = flsh;
    stall_in      = stl;
    #1;
    chk("ready", 80'(iq_ready_out), 80'(exp_rdy));
    hs = v && exp_rdy;
    if (hs && op < 4'h8) begin
      e.strobe = exp_strobe(op);
      e.instr  = ins;
      e.tag    = exp_tag;
      sb.push_back(e);
      exp_tag  = exp_tag + 3'd1;
    end
    @(posedge clk);
    #1;
    if (hs && op < 4'h8) begin
      e = sb.pop_front();
      chk("disp_valid", 80'(disp_valid_out), 80'(e.strobe));
      chk("disp_instr", 80'(disp_instr_out), 80'(e.instr));
      chk("disp_tag",   80'(disp_tag_out),   80'(e.tag));
    end else begin
      chk("disp_idle", 80'(disp_valid_out), 80'(0));
    end
    chk("illegal", 80'(illegal_out), 80'(hs && op >= 4'h8));
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL timeout: simulation did not complete");
  end

  initial begin
    do_reset();

    // FADD credits exhaust after three; a return unblocks one cycle later.
    step(1, 4'h4, 1);
    step(1, 4'h4, 1);
    step(1, 4'h4, 1);
    step(1, 4'h4, 0);
    chk("stall_out_blocked", 80'(stall_out), 80'(1));
    step(1, 4'h4, 0, 4'b0010);
    chk("stall_cnt_1", 80'(stall_cnt_out), 80'(1));
    step(1, 4'h4, 1);
    chk("stall_out_run", 80'(stall_out), 80'(0));
    chk("stall_cnt_2", 80'(stall_cnt_out), 80'(2));
    do_reset();

    // ROB fills at eight; retire frees it, tag wraps to 0.
    for (int i = 0; i < 8; i++) step(1, 4'(i % 4), 1, (i == 2) ? 4'b0001 : 4'b0000);
    step(1, 4'h1, 0);
    step(1, 4'h2, 0, 4'b0000, 1);
    step(1, 4'h3, 1);
    step(0, 4'h0, 0, 4'b0001, 1);
    step(1, 4'h0, 1, 4'b0001, 1);
    step(1, 4'h1, 1);
    step(1, 4'h2, 0, 4'b0001);
    step(1, 4'h3, 0);
    step(0, 4'h0, 0);
    do_reset();

    // Stall, illegal opcode, and FIFO order behind a starved FMUL head.
    step(1, 4'h0, 1);
    step(1, 4'h1, 0, 4'b0000, 0, 0, 1);
    chk("stall_in_no_block", 80'(stall_out), 80'(0));
    step(1, 4'hA, 1);
    step(1, 4'h4, 1);
    step(1, 4'h5, 1);
    step(1, 4'h5, 1);
    step(1, 4'h5, 0);
    step(1, 4'h5, 0);
    chk("fmul_blocked", 80'(stall_out), 80'(1));
    step(1, 4'h5, 0, 4'b0100);
    step(1, 4'h5, 1);
    step(1, 4'h6, 1);
    step(1, 4'h7, 1);
    do_reset();

    // Flush while blocked with five ROB entries in use.
    step(1, 4'h4, 1);
    step(1, 4'h4, 1);
    step(1, 4'h4, 1);
    step(1, 4'h0, 1);
    step(1, 4'h1, 1);
    step(1, 4'h4, 0);
    step(1, 4'h4, 0, 4'b0000, 0, 1);
    exp_tag = '0;
    chk("flush_stall_out", 80'(stall_out), 80'(0));
    chk("flush_keeps_cnt", 80'(stall_cnt_out), 80'(1));
    step(1, 4'h4, 0);
    step(1, 4'h4, 1);
    step(1, 4'h4, 1);
    step(1, 4'h4, 1);
    step(1, 4'h4, 0);
    step(0, 4'h0, 0);
    for (int i = 0; i < 5; i++) step(1, 4'h2, 1);
    step(1, 4'h2, 0);

    // Asynchronous reset drops the strobe from a dispatch in flight.
    step(0, 4'h0, 0, 4'b0000, 1);
    step(1, 4'h3, 1);
    do_reset();
    chk("sb_empty", 80'(sb.size()), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_scheduler.md
# dispatch_scheduler

In-order issue controller between the instruction queue head and the Tomasulo back end. It consumes one instruction per cycle from the queue and classifies it by MajorOpcode into a reservation-station class. It allocates a reorder-buffer tag and dispatches only when both the target station and the ROB have space; otherwise it blocks the queue head, preserving FIFO order.

## Interface
- INT_DEPTH, 4: integer RS slots
- FADD_DEPTH, 3: FP-add RS slots
- FMUL_DEPTH, 2: FP-mul RS slots
- LSB_DEPTH, 4: load/store buffer slots
- ROB_DEPTH, 8: ROB entries (power of two)
- TAG_W, 3: log2(ROB_DEPTH)

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  reset; asynchronous, active-high
- iq_valid_in  in  1  queue head valid
- iq_instr_in  in  75  {MajorOpcode[4], Source1[5], Source2[5], OffsetScale[2], Destination[5], MinorOpcode[4], HasAddress, Address[48], OffsetSub}
- iq_ready_out  out  1  head consumed this edge when high with iq_valid_in
- stall_in  in  1  external stall; blocks consumption
- flush_in  in  1  mispredict/exception flush
- credit_ret_in  in  4  one bit per class {LSB,FMUL,FADD,INT}; each pulse frees one slot
- rob_retire_in  in  1  oldest ROB entry freed
- disp_valid_out  out  4  one-hot class strobe, one cycle
- disp_instr_out  out  75  registered instruction
- disp_tag_out  out  TAG_W  ROB tag
- illegal_out  out  1  one-cycle pulse for an unclassifiable opcode
- stall_out  out  1  high while in BLOCKED
- stall_cnt_out  out  16  saturating count of BLOCKED cycles

## Operation
- Classification (MajorOpcode): 0x0–0x3 INT; 0x4 FADD; 0x5 FMUL; 0x6 load, 0x7 store → LSB; 0x8–0xF illegal.
- Per-class credit counters start at DEPTH. They decrement on dispatch and increment on credit_ret_in. Dispatch and return in the same cycle leaves the counter unchanged. A return at DEPTH is ignored.
- ROB: tail pointer and count start at 0. Alloc: tail+1 mod ROB_DEPTH, count+1. Retire: count−1; a retire at count 0 is ignored. Simultaneous alloc and retire leaves count unchanged.
- can_go = iq_valid_in & !stall_in & !flush_in & state≠FLUSH & (illegal | (credit[class]>0 & rob_count<ROB_DEPTH)).
- iq_ready_out = can_go (combinational).
- Handshake, legal opcode:
  - next cycle disp_valid_out[class]=1, disp_instr_out=iq_instr_in, disp_tag_out=old tail;
  - decrement credit, allocate ROB.
- Handshake, illegal opcode: consumed, illegal_out=1 next cycle, no credit or tag used, disp_valid_out=0.
- FSM:
  - RUN→BLOCKED when iq_valid_in & !stall_in & !can_go & !flush_in;
  - BLOCKED→RUN on handshake, or when iq_valid_in drops;
  - any→FLUSH on flush_in;
  - FLUSH→RUN on the first cycle flush_in is low.
- stall_in holds the FSM in its current state and does not count as BLOCKED.
- Flush: on the edge where flush_in=1, all credits return to DEPTH, ROB tail and count return to 0, and disp_valid_out and illegal_out are 0 next cycle. stall_cnt_out is preserved.

## Timing
- Reset values: iq_ready_out=0, disp_valid_out=0, disp_instr_out=0, disp_tag_out=0, illegal_out=0, stall_out=0, stall_cnt_out=0, state=RUN, credits=DEPTH, ROB count/tail=0.
- Latency: handshake edge N → dispatch strobe visible in cycle N+1. Throughput is 1 per cycle.
- A credit returned in cycle N is usable for can_go in cycle N+1.
- A retire in cycle N frees ROB space in cycle N+1.
- stall_cnt_out increments each cycle state=BLOCKED and saturates at 0xFFFF.
- rst mid-operation: immediate return to reset values. Any in-flight dispatch strobe is dropped.

## Structure
- dispatch_pkg holds:
  - INSTR_W=75 and field offsets;
  - MajorOpcode class constants;
  - class index enum (INT=0, FADD=1, FMUL=2, LSB=3);
  - FSM state typedef (RUN, BLOCKED, FLUSH).
- Sub-module credit_counter (parameter DEPTH; inputs take, give, flush; output avail), instantiated four times.
- ROB tag allocator and FSM live in the top module.

## Test plan
- After reset, issue 0x4 (FADD) 4 times back-to-back with no returns → tags 0,1,2; 4th blocked; stall_out=1 from the 4th cycle. Pulse credit_ret_in[1] → 4th dispatches next cycle with tag 3.
- Issue 9 INT ops with 8 INT credits available (DEPTH overridden) and no retire → 9th blocks on ROB full. One rob_retire_in → dispatches with tag 0 (wrap).
- Opcode 0xA at head → consumed, illegal_out pulses once, disp_valid_out=0, next op gets tag unchanged.
- FMUL credit 0 with LSB op behind it → LSB op does not dispatch (FIFO order held) until an FMUL return arrives.
- Same-cycle INT dispatch and credit_ret_in[0] with credit=1 → credit stays 1. Same-cycle retire and alloc → count unchanged.
- flush_in during BLOCKED with ROB count 5 → next cycle all credits full, count 0, state FLUSH, iq_ready_out=0. Release → RUN; next dispatch tag 0.
